// File: rtl/huge_pages_reg_cpl_pkg.sv
// Shared constants and types for the huge-page register completer.
// TLP fmt/type codes, register offset codes and FSM encodings.
package huge_pages_reg_cpl_pkg;

  localparam logic [6:0] FMT_MRD32 = 7'b00_00000;
  localparam logic [6:0] FMT_CPLD  = 7'b10_01010;

  localparam logic [3:0] OFF_A1_LO = 4'b1010;
  localparam logic [3:0] OFF_A1_HI = 4'b0100;
  localparam logic [3:0] OFF_A2_LO = 4'b1100;
  localparam logic [3:0] OFF_A2_HI = 4'b0101;
  localparam logic [3:0] OFF_Q1    = 4'b1011;
  localparam logic [3:0] OFF_Q2    = 4'b1101;
  localparam logic [3:0] OFF_STAT  = 4'b1110;

  typedef enum logic {
    R_IDLE,
    R_HDR2
  } rx_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_REQ,
    T_B1,
    T_B2
  } tx_state_t;

  typedef struct packed {
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [6:0]  addr;
    logic [31:0] data;
  } cpl_hold_t;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/huge_pages_reg_mux.sv
// Offset-to-register select for the huge-page window.
// Output is byte-swapped into TLP payload byte order.
module huge_pages_reg_mux
  import huge_pages_reg_cpl_pkg::*;
(
  input  logic [3:0]  i_off,
  input  logic [63:0] i_addr_1,
  input  logic [63:0] i_addr_2,
  input  logic [31:0] i_qwords_1,
  input  logic [31:0] i_qwords_2,
  input  logic        i_status_1,
  input  logic        i_status_2,
  output logic [31:0] o_data
);

  logic [31:0] w_val;

  always_comb begin
    w_val = 32'h0;
    unique case (1'b1)
      (i_off == OFF_A1_LO): w_val = i_addr_1[31:0];
      (i_off == OFF_A1_HI): w_val = i_addr_1[63:32];
      (i_off == OFF_A2_LO): w_val = i_addr_2[31:0];
      (i_off == OFF_A2_HI): w_val = i_addr_2[63:32];
      (i_off == OFF_Q1):    w_val = i_qwords_1;
      (i_off == OFF_Q2):    w_val = i_qwords_2;
      (i_off == OFF_STAT):  w_val = {30'b0, i_status_2, i_status_1};
      default:              w_val = 32'h0;
    endcase
  end

  assign o_data = bswap32(w_val);

endmodule

// File: rtl/huge_pages_reg_cpl.sv
// Answers single-DW MRd32 reads of the huge-page register BAR
// with a one-DW CplD on the TRN TX stream.
module huge_pages_reg_cpl
  import huge_pages_reg_cpl_pkg::*;
#(
  parameter int BAR_IDX = 2
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic [63:0] trn_rd,
  input  logic [7:0]  trn_rrem_n,
  input  logic        trn_rsof_n,
  input  logic        trn_reof_n,
  input  logic        trn_rsrc_rdy_n,
  input  logic        trn_rsrc_dsc_n,
  input  logic [6:0]  trn_rbar_hit_n,
  input  logic        trn_rdst_rdy_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  output logic        trn_tsrc_dsc_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [15:0] cfg_completer_id,
  output logic        cpl_req,
  input  logic        cpl_gnt,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic [31:0] huge_page_qwords_1,
  input  logic [31:0] huge_page_qwords_2,
  input  logic        huge_page_status_1,
  input  logic        huge_page_status_2,
  output logic [7:0]  dropped_reads
);

  rx_state_t   r_rx_state;
  tx_state_t   r_tx_state;
  logic [2:0]  r_tc;
  logic [1:0]  r_attr;
  logic [15:0] r_rid;
  logic [7:0]  r_tag;
  cpl_hold_t   r_hold;
  logic        r_full;
  logic [7:0]  r_dropped;
  logic [63:0] r_td;
  logic [7:0]  r_trem_n;
  logic        r_tsof_n;
  logic        r_teof_n;
  logic        r_tsrc_rdy_n;

  logic        w_rx_acc;
  logic        w_rx_hit;
  logic        w_hdr2;
  logic        w_capture;
  logic        w_drop;
  logic        w_tx_done;
  logic [31:0] w_mux_data;
  logic [63:0] w_hdr1;
  logic [63:0] w_beat2;
  logic        w_unused;

  assign w_rx_acc  = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign w_rx_hit  = w_rx_acc & ~trn_rsof_n
                   & ~trn_rbar_hit_n[BAR_IDX]
                   & (trn_rd[62:56] == FMT_MRD32)
                   & (trn_rd[41:32] == 10'd1);
  assign w_hdr2    = (r_rx_state == R_HDR2) & w_rx_acc;
  assign w_capture = w_hdr2 & ~r_full;
  assign w_drop    = w_hdr2 & r_full;
  assign w_tx_done = (r_tx_state == T_B2) & ~trn_tdst_rdy_n;

  assign w_unused = ^{trn_rd, trn_rrem_n, trn_reof_n,
                      trn_rsrc_dsc_n, trn_rbar_hit_n};

  huge_pages_reg_mux u_mux (
    .i_off      (trn_rd[37:34]),
    .i_addr_1   (huge_page_addr_1),
    .i_addr_2   (huge_page_addr_2),
    .i_qwords_1 (huge_page_qwords_1),
    .i_qwords_2 (huge_page_qwords_2),
    .i_status_1 (huge_page_status_1),
    .i_status_2 (huge_page_status_2),
    .o_data     (w_mux_data)
  );

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_rx_state <= R_IDLE;
      r_tc       <= '0;
      r_attr     <= '0;
      r_rid      <= '0;
      r_tag      <= '0;
    end else begin
      case (r_rx_state)
        R_IDLE: begin
          if (w_rx_hit) begin
            r_tc       <= trn_rd[54:52];
            r_attr     <= trn_rd[45:44];
            r_rid      <= trn_rd[31:16];
            r_tag      <= trn_rd[15:8];
            r_rx_state <= R_HDR2;
          end
        end
        R_HDR2: begin
          if (w_rx_acc) r_rx_state <= R_IDLE;
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  // Full holder blocks capture, including on its emptying cycle.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_full    <= 1'b0;
      r_hold    <= '0;
      r_dropped <= 8'h00;
    end else begin
      if (w_capture) begin
        r_full      <= 1'b1;
        r_hold.tc   <= r_tc;
        r_hold.attr <= r_attr;
        r_hold.rid  <= r_rid;
        r_hold.tag  <= r_tag;
        r_hold.addr <= trn_rd[38:32];
        r_hold.data <= w_mux_data;
      end else if (w_tx_done) begin
        r_full <= 1'b0;
      end
      if (w_drop && r_dropped != 8'hFF)
        r_dropped <= r_dropped + 8'd1;
    end
  end

  assign w_hdr1 = {1'b0, FMT_CPLD, 1'b0, r_hold.tc, 4'b0,
                   2'b0, r_hold.attr, 2'b0, 10'd1,
                   cfg_completer_id, 3'b000, 1'b0, 12'd4};

  assign w_beat2 = {r_hold.rid, r_hold.tag, 1'b0,
                    r_hold.addr, r_hold.data};

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_tx_state   <= T_IDLE;
      r_td         <= 64'h0;
      r_trem_n     <= 8'hFF;
      r_tsof_n     <= 1'b1;
      r_teof_n     <= 1'b1;
      r_tsrc_rdy_n <= 1'b1;
    end else begin
      r_trem_n <= 8'h00;
      case (r_tx_state)
        T_IDLE: begin
          if (r_full || w_capture) r_tx_state <= T_REQ;
        end
        T_REQ: begin
          if (cpl_gnt) begin
            r_tx_state   <= T_B1;
            r_td         <= w_hdr1;
            r_tsof_n     <= 1'b0;
            r_teof_n     <= 1'b1;
            r_tsrc_rdy_n <= 1'b0;
          end
        end
        T_B1: begin
          if (!trn_tdst_rdy_n) begin
            r_tx_state <= T_B2;
            r_td       <= w_beat2;
            r_tsof_n   <= 1'b1;
            r_teof_n   <= 1'b0;
          end
        end
        T_B2: begin
          if (!trn_tdst_rdy_n) begin
            r_tx_state   <= T_IDLE;
            r_td         <= 64'h0;
            r_teof_n     <= 1'b1;
            r_tsrc_rdy_n <= 1'b1;
          end
        end
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  assign trn_td         = r_td;
  assign trn_trem_n     = r_trem_n;
  assign trn_tsof_n     = r_tsof_n;
  assign trn_teof_n     = r_teof_n;
  assign trn_tsrc_rdy_n = r_tsrc_rdy_n;
  assign trn_tsrc_dsc_n = 1'b1;
  assign cpl_req        = r_full;
  assign dropped_reads  = r_dropped;

endmodule

// File: tb/tb_huge_pages_reg_cpl.sv
// Directed bench for huge_pages_reg_cpl: MRd32 in, CplD out.
// Expected beats are hand-computed constants.
module tb_huge_pages_reg_cpl;

  logic        trn_clk = 1'b0;
  logic        reset;
  logic [63:0] trn_rd;
  logic [7:0]  trn_rrem_n;
  logic        trn_rsof_n;
  logic        trn_reof_n;
  logic        trn_rsrc_rdy_n;
  logic        trn_rsrc_dsc_n;
  logic [6:0]  trn_rbar_hit_n;
  logic        trn_rdst_rdy_n;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tsrc_dsc_n;
  logic        trn_tdst_rdy_n;
  logic [15:0] cfg_completer_id;
  logic        cpl_req;
  logic        cpl_gnt;
  logic [63:0] huge_page_addr_1;
  logic [63:0] huge_page_addr_2;
  logic [31:0] huge_page_qwords_1;
  logic [31:0] huge_page_qwords_2;
  logic        huge_page_status_1;
  logic        huge_page_status_2;
  logic [7:0]  dropped_reads;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] MRD  = 7'b00_00000;
  localparam logic [6:0] MWR  = 7'b10_00000;
  localparam logic [6:0] BAR2 = 7'b111_1011;
  localparam logic [6:0] BAR0 = 7'b111_1110;
  localparam logic [63:0] H1_T0 = 64'h4A000001_ABCD0004;
  localparam logic [63:0] H1_T5 = 64'h4A502001_ABCD0004;

  always #5 trn_clk = ~trn_clk;

  huge_pages_reg_cpl #(.BAR_IDX(2)) dut (
    .trn_clk            (trn_clk),
    .reset              (reset),
    .trn_rd             (trn_rd),
    .trn_rrem_n         (trn_rrem_n),
    .trn_rsof_n         (trn_rsof_n),
    .trn_reof_n         (trn_reof_n),
    .trn_rsrc_rdy_n     (trn_rsrc_rdy_n),
    .trn_rsrc_dsc_n     (trn_rsrc_dsc_n),
    .trn_rbar_hit_n     (trn_rbar_hit_n),
    .trn_rdst_rdy_n     (trn_rdst_rdy_n),
    .trn_td             (trn_td),
    .trn_trem_n         (trn_trem_n),
    .trn_tsof_n         (trn_tsof_n),
    .trn_teof_n         (trn_teof_n),
    .trn_tsrc_rdy_n     (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n     (trn_tsrc_dsc_n),
    .trn_tdst_rdy_n     (trn_tdst_rdy_n),
    .cfg_completer_id   (cfg_completer_id),
    .cpl_req            (cpl_req),
    .cpl_gnt            (cpl_gnt),
    .huge_page_addr_1   (huge_page_addr_1),
    .huge_page_addr_2   (huge_page_addr_2),
    .huge_page_qwords_1 (huge_page_qwords_1),
    .huge_page_qwords_2 (huge_page_qwords_2),
    .huge_page_status_1 (huge_page_status_1),
    .huge_page_status_2 (huge_page_status_2),
    .dropped_reads      (dropped_reads)
  );

  task automatic tick;
    @(posedge trn_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [63:0] d, input logic sof,
                     input logic eof, input logic [6:0] bar);
    tick();
    trn_rd         = d;
    trn_rsof_n     = sof;
    trn_reof_n     = eof;
    trn_rbar_hit_n = bar;
    trn_rsrc_rdy_n = 1'b0;
  endtask

  task automatic idle;
    tick();
    trn_rsrc_rdy_n = 1'b1;
    trn_rsof_n     = 1'b1;
    trn_reof_n     = 1'b1;
    trn_rbar_hit_n = 7'h7F;
  endtask

  function automatic logic [63:0] h1(input logic [6:0] fmt,
      input logic [2:0] tc, input logic [1:0] attr,
      input logic [9:0] len, input logic [15:0] rid,
      input logic [7:0] tag);
    return {1'b0, fmt, 1'b0, tc, 4'b0, 2'b0, attr, 2'b0, len,
            rid, tag, 8'h0F};
  endfunction

  function automatic logic [63:0] h2(input logic [6:0] a);
    return {25'b0, a, 32'h0};
  endfunction

  task automatic rd_req(input logic [6:0] fmt, input logic [9:0] len,
      input logic [6:0] bar, input logic [15:0] rid,
      input logic [7:0] tag, input logic [6:0] a,
      input logic [2:0] tc, input logic [1:0] attr);
    drv(h1(fmt, tc, attr, len, rid, tag), 1'b0, 1'b1, bar);
    drv(h2(a), 1'b1, 1'b0, bar);
  endtask

  task automatic wait_b1(input string tag);
    int k = 0;
    while (trn_tsrc_rdy_n !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, {63'b0, trn_tsrc_rdy_n}, 64'd0);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      tick();
      if (trn_tsrc_rdy_n === 1'b0) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    reset              = 1'b0;
    trn_rd             = '0;
    trn_rrem_n         = 8'h00;
    trn_rsof_n         = 1'b1;
    trn_reof_n         = 1'b1;
    trn_rsrc_rdy_n     = 1'b1;
    trn_rsrc_dsc_n     = 1'b1;
    trn_rbar_hit_n     = 7'h7F;
    trn_rdst_rdy_n     = 1'b0;
    trn_tdst_rdy_n     = 1'b0;
    cfg_completer_id   = 16'hABCD;
    cpl_gnt            = 1'b0;
    huge_page_addr_1   = 64'h11223344_55667788;
    huge_page_addr_2   = 64'hCAFEF00D_12345678;
    huge_page_qwords_1 = 32'hDEADBEEF;
    huge_page_qwords_2 = 32'h00000040;
    huge_page_status_1 = 1'b1;
    huge_page_status_2 = 1'b0;

    #2 reset = 1'b1;
    #1;
    chk("rst_rdy", {63'b0, trn_tsrc_rdy_n}, 64'd1);
    chk("rst_flags", {60'b0, trn_tsof_n, trn_teof_n,
        trn_tsrc_dsc_n, cpl_req}, 64'hE);
    chk("rst_td", trn_td, 64'd0);
    chk("rst_trem", {56'b0, trn_trem_n}, 64'hFF);
    chk("rst_drop", {56'b0, dropped_reads}, 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // basic read of addr_1 low, grant already held
    cpl_gnt = 1'b1;
    rd_req(MRD, 10'd1, BAR2, 16'h0100, 8'h5A, 7'h28, 3'd0, 2'd0);
    idle();
    chk("t1_req", {63'b0, cpl_req}, 64'd1);
    tick();
    chk("t1_b1_ctl", {61'b0, trn_tsrc_rdy_n, trn_tsof_n,
        trn_teof_n}, 64'd1);
    chk("t1_b1_td", trn_td, H1_T0);
    chk("t1_trem", {56'b0, trn_trem_n}, 64'h00);
    tick();
    chk("t1_b2_ctl", {61'b0, trn_tsrc_rdy_n, trn_tsof_n,
        trn_teof_n}, 64'd2);
    chk("t1_b2_td", trn_td, 64'h01005A28_88776655);
    tick();
    chk("t1_end", {62'b0, trn_tsrc_rdy_n, cpl_req}, 64'd2);

    // status register, non-zero TC and attr
    rd_req(MRD, 10'd1, BAR2, 16'h0203, 8'h11, 7'h38, 3'd5, 2'd2);
    idle();
    wait_b1("t2_b1_seen");
    chk("t2_b1_td", trn_td, H1_T5);
    tick();
    chk("t2_b2_td", trn_td, 64'h02031138_01000000);
    tick();
    chk("t2_end", {63'b0, trn_tsrc_rdy_n}, 64'd1);

    // three reads with grant low, then snapshot check
    cpl_gnt = 1'b0;
    rd_req(MRD, 10'd1, BAR2, 16'h0300, 8'h21, 7'h2C, 3'd0, 2'd0);
    rd_req(MRD, 10'd1, BAR2, 16'h0301, 8'h22, 7'h28, 3'd0, 2'd0);
    rd_req(MRD, 10'd1, BAR2, 16'h0302, 8'h23, 7'h30, 3'd0, 2'd0);
    idle();
    tick();
    tick();
    chk("t31_req", {63'b0, cpl_req}, 64'd1);
    chk("t31_drop", {56'b0, dropped_reads}, 64'd2);
    chk("t31_norun", {63'b0, trn_tsrc_rdy_n}, 64'd1);
    huge_page_qwords_1 = 32'h0;
    tick();
    cpl_gnt = 1'b1;
    wait_b1("t31_b1_seen");
    chk("t31_b1_td", trn_td, H1_T0);
    tick();
    chk("t31_b2_td", trn_td, 64'h0300212C_EFBEADDE);
    quiet("t31_single", 10);

    // request landing on the holder's emptying cycle is dropped
    rd_req(MRD, 10'd1, BAR2, 16'h0500, 8'h44, 7'h30, 3'd0, 2'd0);
    idle();
    drv(h1(MRD, 3'd0, 2'd0, 10'd1, 16'h0600, 8'h55), 1'b0, 1'b1,
        BAR2);
    chk("t23_b1", {62'b0, trn_tsrc_rdy_n, trn_tsof_n}, 64'd0);
    drv(h2(7'h2C), 1'b1, 1'b0, BAR2);
    chk("t23_b2_td", trn_td, 64'h05004430_78563412);
    idle();
    chk("t23_end", {62'b0, trn_tsrc_rdy_n, cpl_req}, 64'd2);
    chk("t23_drop", {56'b0, dropped_reads}, 64'd3);
    quiet("t23_quiet", 10);

    // ignored TLPs: MWr32, wrong BAR, length 2
    rd_req(MWR, 10'd1, BAR2, 16'h0700, 8'h01, 7'h28, 3'd0, 2'd0);
    rd_req(MRD, 10'd1, BAR0, 16'h0700, 8'h02, 7'h28, 3'd0, 2'd0);
    rd_req(MRD, 10'd2, BAR2, 16'h0700, 8'h03, 7'h28, 3'd0, 2'd0);
    idle();
    chk("t32_req", {63'b0, cpl_req}, 64'd0);
    quiet("t32_quiet", 8);
    chk("t32_req2", {63'b0, cpl_req}, 64'd0);
    chk("t32_drop", {56'b0, dropped_reads}, 64'd3);

    // back-pressure on beat 1
    trn_tdst_rdy_n = 1'b1;
    rd_req(MRD, 10'd1, BAR2, 16'h0400, 8'h33, 7'h10, 3'd0, 2'd0);
    idle();
    wait_b1("t30_b1_seen");
    for (int i = 0; i < 6; i++) begin
      chk("t30_hold_td", trn_td, H1_T0);
      chk("t30_hold_ctl", {61'b0, trn_tsrc_rdy_n, trn_tsof_n,
          trn_teof_n}, 64'd1);
      if (i < 5) tick();
    end
    trn_tdst_rdy_n = 1'b0;
    tick();
    chk("t30_b2_td", trn_td, 64'h04003310_44332211);
    chk("t30_b2_req", {63'b0, cpl_req}, 64'd1);
    tick();
    chk("t30_end", {62'b0, trn_tsrc_rdy_n, cpl_req}, 64'd2);
    quiet("t30_single", 10);

    // reset during beat 2
    rd_req(MRD, 10'd1, BAR2, 16'h0800, 8'h66, 7'h34, 3'd0, 2'd0);
    idle();
    wait_b1("t33_b1_seen");
    tick();
    chk("t33_in_b2", {63'b0, trn_teof_n}, 64'd0);
    reset = 1'b1;
    #1;
    chk("t33_rst", {62'b0, trn_tsrc_rdy_n, cpl_req}, 64'd2);
    chk("t33_rst_td", trn_td, 64'd0);
    chk("t33_rst_trem", {56'b0, trn_trem_n}, 64'hFF);
    chk("t33_rst_drop", {56'b0, dropped_reads}, 64'd0);
    tick();
    reset = 1'b0;
    quiet("t33_quiet", 10);
    chk("t33_req", {63'b0, cpl_req}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
